alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU32bit instance (ports A, B, Fun, Out, Z) between two requesters (port 0, port 1).
- Each requester posts an operation {Fun, A, B} through a valid/ready handshake.
- The arbiter grants round-robin, drives the ALU, waits a programmable settle time and captures {Out, Z}.
- It returns the captured result on a shared response channel tagged with the requester ID.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU instance.
- SETTLE, 1, cycles the ALU inputs are held stable before capture; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  per-port request valid; bit i = port i.
- req_ready  output  2  per-port accept strobe; one-hot or zero.
- req_fun0  input  3  port 0 ALU function.
- req_a0  input  WIDTH  port 0 operand A.
- req_b0  input  WIDTH  port 0 operand B.
- req_fun1  input  3  port 1 ALU function.
- req_a1  input  WIDTH  port 1 operand A.
- req_b1  input  WIDTH  port 1 operand B.
- alu_fun  output  3  to ALU Fun.
- alu_a  output  WIDTH  to ALU A.
- alu_b  output  WIDTH  to ALU B.
- alu_out  input  WIDTH  from ALU Out.
- alu_z  input  1  from ALU Z.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  1  requester that owns the result.
- resp_out  output  WIDTH  captured ALU result.
- resp_z  output  1  captured zero flag.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n low): state IDLE, all outputs 0, rr_last=1 (port 0 wins first tie), settle counter 0.
- The reset is asynchronous and active-low, clocked by clk. This is fixed.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - If no req_valid, stay.
  - If exactly one req_valid bit is set, grant that port.
  - If both bits are set, grant ~rr_last.
  - On grant, in the same cycle: req_ready[g]=1 (combinational from state/req_valid), latch {fun,a,b} of port g into operand registers, rr_last<=g, cnt<=SETTLE-1, go SETTLE.
- alu_fun/alu_a/alu_b are driven from the operand registers. They hold their last values in IDLE and RESP and change only on a grant.
- SETTLE:
  - If cnt==0, capture resp_out<=alu_out, resp_z<=alu_z, resp_id<=grant ID, go RESP.
  - Otherwise decrement cnt.
  - With SETTLE=1, capture occurs on the first SETTLE cycle. Latency from accept edge to resp_valid high is SETTLE+1 edges.
- RESP:
  - resp_valid=1; resp_out/resp_z/resp_id held stable until handshake.
  - On resp_ready=1, go IDLE; resp_valid drops next cycle.
  - No new request is accepted in the RESP cycle. Minimum throughput is one operation per SETTLE+2 cycles.
- req_ready is 0 outside IDLE. Requesters must hold payload stable while valid && !ready.
- Deasserting req_valid before acceptance is allowed; the request is simply not granted.
- rst_n asserted mid-operation: the in-flight operation is dropped with no response, and outputs return to reset values immediately.
- Fun codes pass through unmodified; the arbiter does not decode them.

Optional Feature:
- Macro ALU_SHARE_STATS_EN.
- When defined, adds the following outputs, all reset to 0 by rst_n and wrapping modulo 2^16:
  - grant_cnt0 [15:0]: incremented on each port 0 grant.
  - grant_cnt1 [15:0]: incremented on each port 1 grant.
  - zero_cnt [15:0]: incremented on each RESP handshake where resp_z=1.
  - stall_cnt [15:0]: incremented each cycle resp_valid && !resp_ready.
- When undefined, these ports and registers do not exist. Core behaviour is identical in both cases.

Test Plan:
- Reset, then port 0 only, with fun=3'h0, a=32'h5, b=32'h3, resp_ready=1 (ALU add) -> req_ready0 pulses once; resp_valid rises SETTLE+1 edges later with resp_id=0, resp_out=32'h8, resp_z=0.
- Both ports valid in the same cycle, held for 4 operations (port 0: a=b=32'h7, sub; port 1: a=32'h1, b=32'h1, sub) -> grant order 0,1,0,1; every response has resp_z=1 and resp_out=0, with IDs alternating.
- resp_ready held low for 10 cycles in RESP -> resp_out/resp_id are stable and req_ready stays 0 throughout. With stats enabled, stall_cnt=10.
- SETTLE=4 -> alu_a/alu_b are stable for 4 cycles; capture happens on the 4th; resp_valid rises 5 edges after accept.
- rst_n pulsed low during SETTLE -> busy and resp_valid go to 0 immediately and no response appears. The next port 0 request completes normally and is granted first.
- Operand boundary: a=32'hFFFFFFFF, b=32'h1, add -> resp_out=32'h0, resp_z=1 (wrap passed through from the ALU).

Source files
------------

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// alu_share_arbiter: round-robin sharing of one combinational ALU between two
// requesters. Optional stats counters behind macro ALU_SHARE_STATS_EN.
// Revision: 1.0
// ============================================================================
module alu_share_arbiter #(
   parameter int WIDTH  = 32,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [2:0]       req_fun0,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [2:0]       req_fun1,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   output logic [2:0]       alu_fun,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_z,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_out,
   output logic             resp_z,
   output logic             busy
`ifdef ALU_SHARE_STATS_EN
   ,
   output logic [15:0]      grant_cnt0,
   output logic [15:0]      grant_cnt1,
   output logic [15:0]      zero_cnt,
   output logic [15:0]      stall_cnt
`endif
);

   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t     state;
   logic       rr_last;
   logic       owner;
   logic [3:0] cnt;
   logic       grant_vld;
   logic       grant_id;

   // On a tie the port that did not win last time gets the grant.
   always_comb begin
      grant_vld = (state == S_IDLE) && (req_valid != 2'b00);
      grant_id  = (req_valid == 2'b11) ? ~rr_last : req_valid[1];
      req_ready = 2'b00;
      if (grant_vld)
         req_ready = grant_id ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         rr_last    <= 1'b1;
         owner      <= 1'b0;
         cnt        <= 4'd0;
         alu_fun    <= 3'd0;
         alu_a      <= '0;
         alu_b      <= '0;
         resp_valid <= 1'b0;
         resp_id    <= 1'b0;
         resp_out   <= '0;
         resp_z     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_vld) begin
                  alu_fun <= grant_id ? req_fun1 : req_fun0;
                  alu_a   <= grant_id ? req_a1   : req_a0;
                  alu_b   <= grant_id ? req_b1   : req_b0;
                  rr_last <= grant_id;
                  owner   <= grant_id;
                  cnt     <= CNT_INIT;
                  busy    <= 1'b1;
                  state   <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt == 4'd0) begin
                  resp_out   <= alu_out;
                  resp_z     <= alu_z;
                  resp_id    <= owner;
                  resp_valid <= 1'b1;
                  state      <= S_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  busy       <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: begin
               resp_valid <= 1'b0;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

`ifdef ALU_SHARE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0 <= 16'd0;
         grant_cnt1 <= 16'd0;
         zero_cnt   <= 16'd0;
         stall_cnt  <= 16'd0;
      end else begin
         if (req_ready[0])
            grant_cnt0 <= grant_cnt0 + 16'd1;
         if (req_ready[1])
            grant_cnt1 <= grant_cnt1 + 16'd1;
         if (resp_valid && resp_ready && resp_z)
            zero_cnt <= zero_cnt + 16'd1;
         if (resp_valid && !resp_ready)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_share_arbiter: directed bench for alu_share_arbiter with a behavioural
// ALU; instance u_dut uses SETTLE=1, u_dut4 uses SETTLE=4.
// ============================================================================
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          checks = 0;
   int          errors = 0;

   // SETTLE=1 instance signals
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [2:0]  req_fun0 = '0, req_fun1 = '0;
   logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
   logic [2:0]  alu_fun;
   logic [31:0] alu_a, alu_b, alu_out;
   logic        alu_z;
   logic        resp_valid, resp_id, resp_z, busy;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_out;

   // SETTLE=4 instance signals
   logic [1:0]  req_valid_4 = 2'b00;
   logic [1:0]  req_ready_4;
   logic [2:0]  req_fun0_4 = '0, req_fun1_4 = '0;
   logic [31:0] req_a0_4 = '0, req_b0_4 = '0, req_a1_4 = '0, req_b1_4 = '0;
   logic [2:0]  alu_fun_4;
   logic [31:0] alu_a_4, alu_b_4, alu_out_4;
   logic        alu_z_4;
   logic        resp_valid_4, resp_id_4, resp_z_4, busy_4;
   logic        resp_ready_4 = 1'b1;
   logic [31:0] resp_out_4;

`ifdef ALU_SHARE_STATS_EN
   logic [15:0] grant_cnt0, grant_cnt1, zero_cnt, stall_cnt;
   logic [15:0] grant_cnt0_4, grant_cnt1_4, zero_cnt_4, stall_cnt_4;
`endif

   function automatic logic [31:0] alu_f(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   assign alu_out   = alu_f(alu_fun, alu_a, alu_b);
   assign alu_z     = (alu_out == 32'd0);
   assign alu_out_4 = alu_f(alu_fun_4, alu_a_4, alu_b_4);
   assign alu_z_4   = (alu_out_4 == 32'd0);

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(32), .SETTLE(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_fun0(req_fun0), .req_a0(req_a0), .req_b0(req_b0),
      .req_fun1(req_fun1), .req_a1(req_a1), .req_b1(req_b1),
      .alu_fun(alu_fun), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_z(alu_z),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_out(resp_out), .resp_z(resp_z), .busy(busy)
`ifdef ALU_SHARE_STATS_EN
      , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .zero_cnt(zero_cnt), .stall_cnt(stall_cnt)
`endif
   );

   alu_share_arbiter #(.WIDTH(32), .SETTLE(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid_4), .req_ready(req_ready_4),
      .req_fun0(req_fun0_4), .req_a0(req_a0_4), .req_b0(req_b0_4),
      .req_fun1(req_fun1_4), .req_a1(req_a1_4), .req_b1(req_b1_4),
      .alu_fun(alu_fun_4), .alu_a(alu_a_4), .alu_b(alu_b_4), .alu_out(alu_out_4), .alu_z(alu_z_4),
      .resp_valid(resp_valid_4), .resp_ready(resp_ready_4), .resp_id(resp_id_4),
      .resp_out(resp_out_4), .resp_z(resp_z_4), .busy(busy_4)
`ifdef ALU_SHARE_STATS_EN
      , .grant_cnt0(grant_cnt0_4), .grant_cnt1(grant_cnt1_4), .zero_cnt(zero_cnt_4), .stall_cnt(stall_cnt_4)
`endif
   );

   task automatic apply_reset();
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (alu_a !== 32'd0) begin errors++; $display("FAIL reset_alu_a: got %h want 0", alu_a); end
      checks++; if (resp_out !== 32'd0) begin errors++; $display("FAIL reset_resp_out: got %h want 0", resp_out); end
      checks++; if (resp_valid_4 !== 1'b0) begin errors++; $display("FAIL reset_resp_valid_4: got %b want 0", resp_valid_4); end
`ifdef ALU_SHARE_STATS_EN
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
`endif
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      req_fun0 = 3'd0; req_a0 = 32'h5; req_b0 = 32'h3; resp_ready = 1'b1;
      req_valid = 2'b01;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
      @(posedge clk); #1;
      req_valid = 2'b00;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL single_ready_drop: got %b want 00", req_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", resp_valid); end
      checks++; if (alu_a !== 32'h5) begin errors++; $display("FAIL single_alu_a: got %h want 5", alu_a); end
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", resp_valid); end
      checks++; if (resp_id !== 1'b0) begin errors++; $display("FAIL single_id: got %b want 0", resp_id); end
      checks++; if (resp_out !== 32'h8) begin errors++; $display("FAIL single_out: got %h want 8", resp_out); end
      checks++; if (resp_z !== 1'b0) begin errors++; $display("FAIL single_z: got %b want 0", resp_z); end
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", resp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", busy); end
   endtask

   task automatic test_round_robin();
      int n;
      logic [1:0] exp_rdy;
      apply_reset();
      req_fun0 = 3'd1; req_a0 = 32'h7; req_b0 = 32'h7;
      req_fun1 = 3'd1; req_a1 = 32'h1; req_b1 = 32'h1;
      resp_ready = 1'b1;
      req_valid = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         exp_rdy = (k % 2 == 1) ? 2'b10 : 2'b01;
         n = 0;
         while (req_ready == 2'b00 && n < 20) begin @(posedge clk); #1; n++; end
         checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, exp_rdy); end
         @(posedge clk); #1;
         n = 0;
         while (resp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
         checks++; if (resp_id !== exp_rdy[1]) begin errors++; $display("FAIL rr_id%0d: got %b want %b", k, resp_id, exp_rdy[1]); end
         checks++; if (resp_out !== 32'h0) begin errors++; $display("FAIL rr_out%0d: got %h want 0", k, resp_out); end
         checks++; if (resp_z !== 1'b1) begin errors++; $display("FAIL rr_z%0d: got %b want 1", k, resp_z); end
         @(posedge clk); #1;
      end
      req_valid = 2'b00;
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      apply_reset();
      req_fun0 = 3'd0; req_a0 = 32'd10; req_b0 = 32'd20;
      resp_ready = 1'b0;
      req_valid = 2'b01;
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", resp_valid); end
      req_fun1 = 3'd0; req_a1 = 32'd1; req_b1 = 32'd2;
      req_valid = 2'b10;
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready_resp: got %b want 00", req_ready); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid%0d: got %b want 1", i, resp_valid); end
         checks++; if (resp_out !== 32'd30) begin errors++; $display("FAIL bp_hold_out%0d: got %h want 1e", i, resp_out); end
         checks++; if (resp_id !== 1'b0) begin errors++; $display("FAIL bp_hold_id%0d: got %b want 0", i, resp_id); end
         checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_hold_ready%0d: got %b want 00", i, req_ready); end
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", resp_valid); end
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_ready: got %b want 10", req_ready); end
`ifdef ALU_SHARE_STATS_EN
      checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL bp_stall_cnt: got %0d want 10", stall_cnt); end
`endif
      // Withdrawing the pending request before the edge must leave the arbiter idle.
      req_valid = 2'b00;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_withdraw_busy: got %b want 0", busy); end
   endtask

   task automatic test_settle4();
      apply_reset();
      req_fun0_4 = 3'd0; req_a0_4 = 32'd100; req_b0_4 = 32'd23;
      resp_ready_4 = 1'b1;
      req_valid_4 = 2'b01;
      @(posedge clk); #1;
      req_valid_4 = 2'b00; req_a0_4 = 32'hDEAD; req_b0_4 = 32'h0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (resp_valid_4 !== 1'b0) begin errors++; $display("FAIL s4_early_valid%0d: got %b want 0", i, resp_valid_4); end
         checks++; if (alu_a_4 !== 32'd100) begin errors++; $display("FAIL s4_alu_a%0d: got %h want 64", i, alu_a_4); end
         checks++; if (alu_b_4 !== 32'd23) begin errors++; $display("FAIL s4_alu_b%0d: got %h want 17", i, alu_b_4); end
         @(posedge clk); #1;
      end
      checks++; if (resp_valid_4 !== 1'b1) begin errors++; $display("FAIL s4_valid: got %b want 1", resp_valid_4); end
      checks++; if (resp_out_4 !== 32'd123) begin errors++; $display("FAIL s4_out: got %h want 7b", resp_out_4); end
      checks++; if (resp_id_4 !== 1'b0) begin errors++; $display("FAIL s4_id: got %b want 0", resp_id_4); end
      @(posedge clk); #1;
      checks++; if (resp_valid_4 !== 1'b0) begin errors++; $display("FAIL s4_valid_drop: got %b want 0", resp_valid_4); end
   endtask

   task automatic test_reset_mid();
      req_fun1 = 3'd0; req_a1 = 32'd2; req_b1 = 32'd3;
      resp_ready = 1'b1;
      req_valid = 2'b10;
      @(posedge clk); #1;
      req_valid = 2'b00;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_async: got %b want 0", busy); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_async: got %b want 0", resp_valid); end
      #2 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_resp%0d: got %b want 0", i, resp_valid); end
      end
      req_fun0 = 3'd2; req_a0 = 32'h0000F0F0; req_b0 = 32'h0000FF00;
      req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_first_grant: got %b want 01", req_ready); end
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL mid_valid: got %b want 1", resp_valid); end
      checks++; if (resp_id !== 1'b0) begin errors++; $display("FAIL mid_id: got %b want 0", resp_id); end
      checks++; if (resp_out !== 32'h0000F000) begin errors++; $display("FAIL mid_out: got %h want 0000f000", resp_out); end
      @(posedge clk); #1;
   endtask

   task automatic test_boundary();
      req_fun0 = 3'd0; req_a0 = 32'hFFFFFFFF; req_b0 = 32'h1;
      resp_ready = 1'b1;
      req_valid = 2'b01;
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bound_valid: got %b want 1", resp_valid); end
      checks++; if (resp_out !== 32'h0) begin errors++; $display("FAIL bound_out: got %h want 0", resp_out); end
      checks++; if (resp_z !== 1'b1) begin errors++; $display("FAIL bound_z: got %b want 1", resp_z); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_settle4();
      test_reset_mid();
      test_boundary();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
